// File: rtl/flash_read_ctrl.sv
// SPI flash read sequencer: optional wake-up, then READ + 24-bit address, dummy bytes out, data bytes streamed back.
// Owns flash_cs_n for the whole transaction and keeps exactly one byte outstanding on the byte engine.
module flash_read_ctrl #(
  parameter int          LEN_W            = 12,
  parameter int          CS_HIGH_CYCLES   = 4,
  parameter int          WAKE_ON_RESET    = 1,
  parameter int          WAKE_WAIT_CYCLES = 200,
  parameter logic [7:0]  READ_CMD         = 8'h03,
  parameter logic [7:0]  WAKE_CMD         = 8'hAB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             abort,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             busy,
  output logic             flash_cs_n,
  output logic             byte_start,
  output logic [7:0]       byte_tx,
  input  logic [7:0]       byte_rx,
  input  logic             byte_done
);

  localparam int CNT_MAX = (WAKE_WAIT_CYCLES > CS_HIGH_CYCLES) ? WAKE_WAIT_CYCLES : CS_HIGH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_WAKE_CMD, S_WAKE_WAIT, S_IDLE, S_CS_SETUP, S_CMD,
    S_A2, S_A1, S_A0, S_DATA, S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             pend_q, pend_d;
  logic             abort_q, abort_d;
  logic             cs_n_q, cs_n_d;
  logic             byte_start_q, byte_start_d;
  logic [7:0]       byte_tx_q, byte_tx_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             done_q, done_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    pend_d       = pend_q;
    abort_d      = abort_q;
    cs_n_d       = cs_n_q;
    byte_start_d = 1'b0;
    byte_tx_d    = byte_tx_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    done_d       = 1'b0;
    req_ready_d  = 1'b0;

    case (state_q)
      // Three phases: drop cs_n, issue the opcode, then wait for it to finish.
      S_WAKE_CMD: begin
        if (cs_n_q) begin
          cs_n_d = 1'b0;
        end else if (!pend_q) begin
          byte_start_d = 1'b1;
          byte_tx_d    = WAKE_CMD;
          pend_d       = 1'b1;
        end else if (byte_done) begin
          pend_d = 1'b0;
          cs_n_d = 1'b1;
          if (WAKE_WAIT_CYCLES <= 1) begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
          end else begin
            state_d = S_WAKE_WAIT;
            cnt_d   = CNT_W'(WAKE_WAIT_CYCLES - 1);
          end
        end
      end
      S_WAKE_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          rem_d   = req_len;
          abort_d = 1'b0;
          if (req_len == '0) begin
            done_d = 1'b1;
          end else begin
            cs_n_d  = 1'b0;
            state_d = S_CS_SETUP;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_CS_SETUP: begin
        byte_start_d = 1'b1;
        byte_tx_d    = READ_CMD;
        pend_d       = 1'b1;
        state_d      = S_CMD;
      end
      S_CMD, S_A2, S_A1, S_A0, S_DATA: begin
        if (abort) abort_d = 1'b1;
        if (pend_q && byte_done) begin
          pend_d = 1'b0;
          if (state_q == S_DATA) begin
            rd_valid_d = 1'b1;
            rd_data_d  = byte_rx;
            rem_d      = rem_q - LEN_W'(1);
          end
          // A pending or same-cycle abort ends the transaction on this byte.
          if (abort_q || abort || (state_q == S_DATA && rem_q == LEN_W'(1))) begin
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_GAP;
            cnt_d   = CNT_W'(CS_HIGH_CYCLES);
          end else begin
            byte_start_d = 1'b1;
            pend_d       = 1'b1;
            case (state_q)
              S_CMD:   begin state_d = S_A2;   byte_tx_d = addr_q[23:16]; end
              S_A2:    begin state_d = S_A1;   byte_tx_d = addr_q[15:8];  end
              S_A1:    begin state_d = S_A0;   byte_tx_d = addr_q[7:0];   end
              default: begin state_d = S_DATA; byte_tx_d = 8'h00;         end
            endcase
          end
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          req_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= (WAKE_ON_RESET != 0) ? S_WAKE_CMD : S_GAP;
      cnt_q        <= (WAKE_ON_RESET != 0) ? '0 : CNT_W'(CS_HIGH_CYCLES);
      addr_q       <= '0;
      rem_q        <= '0;
      pend_q       <= 1'b0;
      abort_q      <= 1'b0;
      cs_n_q       <= 1'b1;
      byte_start_q <= 1'b0;
      byte_tx_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      done_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      pend_q       <= pend_d;
      abort_q      <= abort_d;
      cs_n_q       <= cs_n_d;
      byte_start_q <= byte_start_d;
      byte_tx_q    <= byte_tx_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      done_q       <= done_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign flash_cs_n = cs_n_q;
  assign byte_start = byte_start_q;
  assign byte_tx    = byte_tx_q;

endmodule
